// File: rtl/mul_addtree_pipe.sv
// mul_addtree_pipe: pipelined signed/unsigned shift-and-add multiplier with a registered adder tree and valid/ready stall
module mul_addtree_pipe #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out
);
    localparam int LG = $clog2(W);

    logic             w_stall;
    logic [W-1:0]     r_mx;
    logic [W-1:0]     r_my;
    logic             r_neg;
    logic             r_v0;
    logic [2*W-1:0]   r_out;
    logic             r_ov;

    assign w_stall   = r_ov & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = r_ov;
    assign out       = r_out;

    // stage 0: operand magnitudes and product sign; a bubble enters whenever nothing is offered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mx  <= '0;
            r_my  <= '0;
            r_neg <= 1'b0;
            r_v0  <= 1'b0;
        end else if (!w_stall) begin
            r_mx  <= (signed_mode & x[W-1]) ? -x : x;
            r_my  <= (signed_mode & y[W-1]) ? -y : y;
            r_neg <= signed_mode & (x[W-1] ^ y[W-1]);
            r_v0  <= in_valid;
        end
    end

    genvar g;
    for (g = 0; g <= LG; g++) begin : lvl
        logic [2*W-1:0] w_s [0:(W>>g)-1];
        logic           w_v;
        logic           w_n;
        if (g == 0) begin : g_pp
            assign w_v = r_v0;
            assign w_n = r_neg;
            // partial products straight from the stage-0 magnitudes
            always_comb begin
                for (int i = 0; i < W; i++)
                    w_s[i] = r_my[i] ? ({{W{1'b0}}, r_mx} << i) : '0;
            end
        end else begin : g_add
            logic [2*W-1:0] r_s [0:(W>>g)-1];
            logic           r_v;
            logic           r_n;
            assign w_s = r_s;
            assign w_v = r_v;
            assign w_n = r_n;
            // one tree level: pairwise sums of the level below, sign and valid ride along
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < (W>>g); i++)
                        r_s[i] <= '0;
                    r_v <= 1'b0;
                    r_n <= 1'b0;
                end else if (!w_stall) begin
                    for (int i = 0; i < (W>>g); i++)
                        r_s[i] <= lvl[g-1].w_s[2*i] + lvl[g-1].w_s[2*i+1];
                    r_v <= lvl[g-1].w_v;
                    r_n <= lvl[g-1].w_n;
                end
            end
        end
    end

    // output stage: reapply the sign to the unsigned magnitude product
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
            r_ov  <= 1'b0;
        end else if (!w_stall) begin
            r_out <= lvl[LG].w_n ? -lvl[LG].w_s[0] : lvl[LG].w_s[0];
            r_ov  <= lvl[LG].w_v;
        end
    end
endmodule
